// File: rtl/mmix_defs_pkg.sv
// Shared MMIX definitions: memory access sizes and the bridge request payload.
package mmix_defs;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned BUS_W  = 32;
  localparam int unsigned BE_W   = 4;

  // Access size as encoded on the load/store unit's mem_datasize port.
  typedef enum logic [1:0] {
    BYTE  = 2'd0,
    WYDE  = 2'd1,
    TETRA = 2'd2,
    OCTA  = 2'd3
  } mem_size_t;

  // Request fields the bridge keeps once a request has been captured.
  typedef struct packed {
    mem_size_t           size;
    logic [1:0]          offset;
    logic [DATA_W-1:0]   wdata;
  } mem_req_t;

  // Mask that clears the address bits below the natural alignment of size.
  function automatic logic [DATA_W-1:0] align_mask(input mem_size_t size);
    return ~((DATA_W'(1) << size) - DATA_W'(1));
  endfunction

endpackage

// File: rtl/mmix_mem_bridge_if.sv
// Interfaces on both sides of the bridge: the load/store unit port and the
// Avalon-MM bus port.

// Load/store unit request port; master is the load/store unit.
interface mmix_mem_if;
  logic [63:0] address;
  logic [1:0]  datasize;
  logic        read;
  logic        write;
  logic [63:0] writedata;
  logic [63:0] readdata;
  logic        done;

  modport master (
    output address, datasize, read, write, writedata,
    input  readdata, done
  );

  modport slave (
    input  address, datasize, read, write, writedata,
    output readdata, done
  );
endinterface

// 32-bit Avalon-MM port; master is the bridge.
interface avalon_mm_if #(
  parameter int unsigned ADDR_W = 32
);
  logic [ADDR_W-1:0] address;
  logic [3:0]        byteenable;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic              waitrequest;
  logic              readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  readdata, waitrequest, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output readdata, waitrequest, readdatavalid
  );
endinterface

// File: rtl/mmix_mem_bridge_lane_steer.sv
// Big-endian lane steering between the 64-bit right-justified request data
// and the 32-bit bus: byte enables, write replication and read extraction.
module mem_lane_steer
  import mmix_defs::*;
(
  input  mem_size_t   size,
  input  logic [1:0]  offset,
  input  logic        beat,
  input  logic [63:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  byteenable_c,
  output logic [31:0] wdata_c,
  output logic [31:0] rdata_c
);

  // Lane selection; byte address offset 0 lives in bits 31:24.
  always_comb begin
    byteenable_c = 4'b1111;
    wdata_c      = wdata[31:0];
    rdata_c      = rdata;
    case (size)
      BYTE: begin
        byteenable_c = 4'b1000 >> offset;
        wdata_c      = {4{wdata[7:0]}};
        case (offset)
          2'd0:    rdata_c = {24'd0, rdata[31:24]};
          2'd1:    rdata_c = {24'd0, rdata[23:16]};
          2'd2:    rdata_c = {24'd0, rdata[15:8]};
          default: rdata_c = {24'd0, rdata[7:0]};
        endcase
      end
      WYDE: begin
        byteenable_c = offset[1] ? 4'b0011 : 4'b1100;
        wdata_c      = {2{wdata[15:0]}};
        rdata_c      = offset[1] ? {16'd0, rdata[15:0]} : {16'd0, rdata[31:16]};
      end
      OCTA: begin
        wdata_c = beat ? wdata[31:0] : wdata[63:32];
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/mmix_mem_bridge.sv
// Bridge from the MMIX load/store unit's held, size-tagged 64-bit requests to
// aligned big-endian accesses on a 32-bit Avalon-MM master port.
module mmix_mem_bridge
  import mmix_defs::*;
#(
  parameter int unsigned ADDR_W = 32
)(
  input  logic         clk,
  input  logic         reset_n,
  mmix_mem_if.slave    mem,
  avalon_mm_if.master  avm
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD0  = 3'd1;
  localparam logic [2:0] S_RD1  = 3'd2;
  localparam logic [2:0] S_WR0  = 3'd3;
  localparam logic [2:0] S_WR1  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]        state_q, state_d;
  mem_req_t          req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [BUS_W-1:0]  wdata_q, wdata_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [BUS_W-1:0]  hi_q, hi_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              done_q, done_d;

  mem_size_t         in_size;
  logic [ADDR_W-1:0] ea;
  logic              is_octa;

  mem_size_t         st_size;
  logic [1:0]        st_offset;
  logic              st_beat;
  logic [DATA_W-1:0] st_wdata;
  logic [BE_W-1:0]   st_be_c;
  logic [BUS_W-1:0]  st_wdata_c;
  logic [BUS_W-1:0]  st_rdata_c;

  // Address bits above the bus width are discarded.
  if (ADDR_W < DATA_W) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^mem.address[DATA_W-1:ADDR_W];
  end

  // Silently aligned effective address of the incoming request.
  always_comb begin
    in_size = mem_size_t'(mem.datasize);
    ea      = ADDR_W'(mem.address) & ADDR_W'(align_mask(in_size));
    is_octa = (req_q.size == OCTA);
  end

  // Steering looks at the incoming request in IDLE and at the captured one
  // afterwards, where the only new command it prepares is the second beat.
  always_comb begin
    if (state_q == S_IDLE) begin
      st_size   = in_size;
      st_offset = ea[1:0];
      st_beat   = 1'b0;
      st_wdata  = mem.writedata;
    end else begin
      st_size   = req_q.size;
      st_offset = req_q.offset;
      st_beat   = 1'b1;
      st_wdata  = req_q.wdata;
    end
  end

  mem_lane_steer u_steer (
    .size         (st_size),
    .offset       (st_offset),
    .beat         (st_beat),
    .wdata        (st_wdata),
    .rdata        (avm.readdata),
    .byteenable_c (st_be_c),
    .wdata_c      (st_wdata_c),
    .rdata_c      (st_rdata_c)
  );

  // Next state and next register values for the bus sequencer.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    hi_d    = hi_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (mem.read || mem.write) begin
          req_d.size   = in_size;
          req_d.offset = ea[1:0];
          req_d.wdata  = mem.writedata;
          addr_d       = {ea[ADDR_W-1:2], 2'b00};
          be_d         = st_be_c;
          wdata_d      = mem.read ? BUS_W'(0) : st_wdata_c;
          rd_d         = mem.read;
          wr_d         = !mem.read;
          state_d      = mem.read ? S_RD0 : S_WR0;
        end
      end

      S_WR0: begin
        if (!avm.waitrequest) begin
          if (is_octa) begin
            addr_d  = addr_q + ADDR_W'(4);
            wdata_d = st_wdata_c;
            state_d = S_WR1;
          end else begin
            wr_d    = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end

      S_WR1: begin
        if (!avm.waitrequest) begin
          wr_d    = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end

      S_RD0: begin
        if (rd_q) begin
          if (!avm.waitrequest) rd_d = 1'b0;
        end else if (avm.readdatavalid) begin
          if (is_octa) begin
            hi_d    = avm.readdata;
            addr_d  = addr_q + ADDR_W'(4);
            rd_d    = 1'b1;
            state_d = S_RD1;
          end else begin
            rdata_d = {32'd0, st_rdata_c};
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end

      S_RD1: begin
        if (rd_q) begin
          if (!avm.waitrequest) rd_d = 1'b0;
        end else if (avm.readdatavalid) begin
          rdata_d = {hi_q, avm.readdata};
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      hi_q    <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      hi_q    <= hi_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
    end
  end

  assign avm.address    = addr_q;
  assign avm.byteenable = be_q;
  assign avm.read       = rd_q;
  assign avm.write      = wr_q;
  assign avm.writedata  = wdata_q;
  assign mem.readdata   = rdata_q;
  assign mem.done       = done_q;

endmodule

// File: tb/tb_mmix_mem_bridge.sv
// Self-checking bench for mmix_mem_bridge: byte-level memory reference model,
// Avalon slave with configurable stalls and read latency.
module tb_mmix_mem_bridge;
  import mmix_defs::*;

  localparam int unsigned ADDR_W = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  mmix_mem_if mem_bus();
  avalon_mm_if #(.ADDR_W(ADDR_W)) avm_bus();

  mmix_mem_bridge #(.ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .mem     (mem_bus.slave),
    .avm     (avm_bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_read;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } beat_t;

  int checks = 0;
  int failures = 0;
  int done_count = 0;
  int stall_per_beat = 0;
  int rdv_delay = 0;
  bit spurious_rdv = 1'b0;
  logic [63:0] exp_hold = 64'd0;
  beat_t beat_log[$];
  logic [7:0] slave_mem [int unsigned];
  logic [7:0] model_mem [int unsigned];

  function automatic logic [7:0] def_byte(input int unsigned a);
    return 8'(a * 37 + 11);
  endfunction

  function automatic logic [7:0] slave_byte(input int unsigned a);
    return slave_mem.exists(a) ? slave_mem[a] : def_byte(a);
  endfunction

  function automatic logic [7:0] model_byte(input int unsigned a);
    return model_mem.exists(a) ? model_mem[a] : def_byte(a);
  endfunction

  // Same big-endian word placed in both memories.
  task automatic preload(input int unsigned a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      slave_mem[a + i] = w[31 - 8*i -: 8];
      model_mem[a + i] = w[31 - 8*i -: 8];
    end
  endtask

  // Count every cycle in which mem_done is high.
  always @(posedge clk) if (mem_bus.done === 1'b1) done_count++;

  // Avalon slave: stalls each command, logs accepted beats, returns read data.
  initial begin
    int stall_left;
    bit in_cmd;
    bit rdv_pending;
    int rdv_wait;
    logic [31:0] rdv_data;
    logic [69:0] snap;
    logic [69:0] cur;
    logic [31:0] w;
    beat_t b;
    stall_left = 0; in_cmd = 0; rdv_pending = 0; rdv_wait = 0; rdv_data = 0; snap = '0;
    avm_bus.waitrequest = 1'b0;
    avm_bus.readdatavalid = 1'b0;
    avm_bus.readdata = 32'd0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        avm_bus.waitrequest = 1'b0;
        avm_bus.readdatavalid = 1'b0;
        in_cmd = 0;
        rdv_pending = 0;
      end else begin
        avm_bus.readdatavalid = 1'b0;
        if (rdv_pending) begin
          if (rdv_wait == 0) begin
            avm_bus.readdatavalid = 1'b1;
            avm_bus.readdata = rdv_data;
            rdv_pending = 0;
          end else begin
            rdv_wait--;
          end
        end else if (spurious_rdv) begin
          avm_bus.readdatavalid = 1'b1;
          avm_bus.readdata = $urandom;
        end
        cur = {avm_bus.read, avm_bus.write, avm_bus.address, avm_bus.byteenable, avm_bus.writedata};
        if (avm_bus.read === 1'b1 || avm_bus.write === 1'b1) begin
          if (!in_cmd) begin
            in_cmd = 1;
            stall_left = stall_per_beat;
            snap = cur;
          end else begin
            checks++;
            if (cur !== snap) begin
              failures++;
              $display("FAIL cmd_stable actual=%h expected=%h", cur, snap);
            end
          end
          if (stall_left > 0) begin
            avm_bus.waitrequest = 1'b1;
            stall_left--;
          end else begin
            avm_bus.waitrequest = 1'b0;
            in_cmd = 0;
            b.is_read = avm_bus.read;
            b.addr = avm_bus.address;
            b.be = avm_bus.byteenable;
            b.wdata = avm_bus.writedata;
            beat_log.push_back(b);
            if (avm_bus.read === 1'b1) begin
              for (int i = 0; i < 4; i++) w[31 - 8*i -: 8] = slave_byte(b.addr + i);
              rdv_data = w;
              rdv_pending = 1;
              rdv_wait = rdv_delay;
            end else begin
              for (int i = 0; i < 4; i++)
                if (b.be[3 - i]) slave_mem[b.addr + i] = b.wdata[31 - 8*i -: 8];
            end
          end
        end else begin
          avm_bus.waitrequest = 1'b0;
          in_cmd = 0;
        end
      end
    end
  end

  // Present a request at a falling edge and hold it until mem_done.
  task automatic do_txn(input logic rd, input logic wr, input int size,
                        input logic [63:0] addr, input logic [63:0] wd, output int lat);
    mem_bus.read = rd;
    mem_bus.write = wr;
    mem_bus.datasize = 2'(size);
    mem_bus.address = addr;
    mem_bus.writedata = wd;
    lat = 0;
    while (1) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (mem_bus.done === 1'b1) break;
      if (lat >= 200) begin
        checks++;
        failures++;
        $display("FAIL txn_timeout actual=no_done expected=done_within_200");
        break;
      end
    end
    mem_bus.read = 1'b0;
    mem_bus.write = 1'b0;
  endtask

  // One request checked against the byte-level model: beats, latency, data, done.
  task automatic check_txn(input string name, input logic rd, input int size,
                           input logic [63:0] addr, input logic [63:0] wd,
                           input int stall, input int rdvd);
    int unsigned n, ea, word;
    int exp_lat, lat, dc0;
    logic [3:0] be;
    logic [31:0] wrep;
    logic [63:0] v;
    beat_t exp_q[$];
    beat_t e;
    n = 32'd1 << size;
    ea = 32'(addr) & ~(n - 1);
    exp_q.delete();
    if (n == 8) begin
      e.is_read = rd; e.addr = ea; e.be = 4'b1111; e.wdata = wd[63:32]; exp_q.push_back(e);
      e.addr = ea + 4; e.wdata = wd[31:0]; exp_q.push_back(e);
    end else begin
      word = ea & ~32'd3;
      be = 4'b0000;
      for (int unsigned i = 0; i < n; i++) be[3 - ((ea + i) % 4)] = 1'b1;
      if (n == 1) wrep = {4{wd[7:0]}};
      else if (n == 2) wrep = {2{wd[15:0]}};
      else wrep = wd[31:0];
      e.is_read = rd; e.addr = word; e.be = be; e.wdata = wrep; exp_q.push_back(e);
    end
    if (rd) begin
      v = 64'd0;
      for (int unsigned i = 0; i < n; i++) v = {v[55:0], model_byte(ea + i)};
      exp_hold = v;
      exp_lat = 1 + exp_q.size() * (2 + stall + rdvd);
    end else begin
      for (int unsigned i = 0; i < n; i++) model_mem[ea + i] = wd[8*(n - 1 - i) +: 8];
      exp_lat = 1 + exp_q.size() * (1 + stall);
    end
    beat_log.delete();
    stall_per_beat = stall;
    rdv_delay = rdvd;
    dc0 = done_count;
    do_txn(rd, !rd, size, addr, wd, lat);
    checks++;
    if (lat !== exp_lat) begin
      failures++;
      $display("FAIL %s latency actual=%0d expected=%0d", name, lat, exp_lat);
    end
    checks++;
    if (mem_bus.readdata !== exp_hold) begin
      failures++;
      $display("FAIL %s readdata actual=%h expected=%h", name, mem_bus.readdata, exp_hold);
    end
    checks++;
    if (beat_log.size() != exp_q.size()) begin
      failures++;
      $display("FAIL %s beat_count actual=%0d expected=%0d", name, beat_log.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (beat_log[i].is_read !== exp_q[i].is_read || beat_log[i].addr !== exp_q[i].addr ||
            beat_log[i].be !== exp_q[i].be || (!rd && beat_log[i].wdata !== exp_q[i].wdata)) begin
          failures++;
          $display("FAIL %s beat%0d actual=r%0b a=%h be=%b d=%h expected=r%0b a=%h be=%b d=%h",
                   name, i, beat_log[i].is_read, beat_log[i].addr, beat_log[i].be, beat_log[i].wdata,
                   exp_q[i].is_read, exp_q[i].addr, exp_q[i].be, exp_q[i].wdata);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (mem_bus.done !== 1'b0 || done_count != dc0 + 1) begin
      failures++;
      $display("FAIL %s done_pulse actual=done%0b count%0d expected=done0 count%0d",
               name, mem_bus.done, done_count - dc0, 1);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if ({avm_bus.read, avm_bus.write, mem_bus.done} !== 3'b000) begin
      failures++;
      $display("FAIL %s strobes actual=%b expected=000", name, {avm_bus.read, avm_bus.write, mem_bus.done});
    end
    checks++;
    if ({avm_bus.address, avm_bus.byteenable, avm_bus.writedata} !== 68'd0) begin
      failures++;
      $display("FAIL %s bus_fields actual=%h expected=0", name,
               {avm_bus.address, avm_bus.byteenable, avm_bus.writedata});
    end
    checks++;
    if (mem_bus.readdata !== 64'd0) begin
      failures++;
      $display("FAIL %s readdata actual=%h expected=0", name, mem_bus.readdata);
    end
  endtask

  task automatic test_reset();
    mem_bus.read = 1'b0;
    mem_bus.write = 1'b0;
    mem_bus.datasize = 2'd0;
    mem_bus.address = 64'd0;
    mem_bus.writedata = 64'd0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    check_txn("byte_wr", 1'b0, 0, 64'h1003, 64'hAB, 0, 0);
    preload(32'h2000, 32'h1122_3344);
    check_txn("wyde_rd", 1'b1, 1, 64'h2002, 64'd0, 0, 0);
    check_txn("wyde_rd_mis", 1'b1, 1, 64'h2003, 64'd0, 0, 0);
    preload(32'h3000, 32'hDEAD_BEEF);
    preload(32'h3004, 32'h0123_4567);
    check_txn("octa_rd", 1'b1, 3, 64'h3005, 64'd0, 0, 0);
    check_txn("octa_wr_stall", 1'b0, 3, 64'hFFFF_0000_0000_4000, 64'h8877_6655_4433_2211, 2, 0);
    check_txn("octa_rd_back", 1'b1, 3, 64'h4000, 64'd0, 1, 1);
    check_txn("byte_rd_hi", 1'b1, 0, 64'h4000, 64'd0, 0, 2);
  endtask

  // Read immediately followed by write, then read and write raised together.
  task automatic test_back_to_back();
    int lat_r, lat_w, dc0;
    preload(32'h5000, 32'hCAFE_F00D);
    preload(32'h5004, 32'h0BAD_F00D);
    for (int v = 0; v < 2; v++) begin
      logic [31:0] a;
      a = (v == 0) ? 32'h5000 : 32'h5004;
      beat_log.delete();
      stall_per_beat = 0;
      rdv_delay = 0;
      dc0 = done_count;
      do_txn(1'b1, 1'(v), 2, 64'(a), 64'h0000_0000_1357_9BDF, lat_r);
      do_txn(1'b0, 1'b1, 2, 64'(a), 64'h0000_0000_1357_9BDF, lat_w);
      for (int i = 0; i < 4; i++) model_mem[a + i] = 8'(32'h1357_9BDF >> (24 - 8*i));
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (lat_r != 3 || lat_w != 3) begin
        failures++;
        $display("FAIL b2b%0d latency actual=%0d,%0d expected=3,3", v, lat_r, lat_w);
      end
      checks++;
      if (mem_bus.readdata !== ((v == 0) ? 64'hCAFE_F00D : 64'h0BAD_F00D)) begin
        failures++;
        $display("FAIL b2b%0d readdata actual=%h", v, mem_bus.readdata);
      end
      exp_hold = (v == 0) ? 64'hCAFE_F00D : 64'h0BAD_F00D;
      checks++;
      if (beat_log.size() != 2 || beat_log[0].is_read !== 1'b1 || beat_log[1].is_read !== 1'b0 ||
          beat_log[0].addr !== a || beat_log[1].addr !== a || beat_log[1].wdata !== 32'h1357_9BDF) begin
        failures++;
        $display("FAIL b2b%0d beats actual=count%0d expected=read_then_write", v, beat_log.size());
      end
      checks++;
      if (done_count != dc0 + 2) begin
        failures++;
        $display("FAIL b2b%0d done_count actual=%0d expected=2", v, done_count - dc0);
      end
    end
  endtask

  // readdatavalid while idle must neither complete nor alter the load data.
  task automatic test_spurious_rdv();
    int dc0;
    dc0 = done_count;
    spurious_rdv = 1'b1;
    repeat (4) @(negedge clk);
    spurious_rdv = 1'b0;
    @(negedge clk);
    checks++;
    if (done_count != dc0 || mem_bus.readdata !== exp_hold) begin
      failures++;
      $display("FAIL spurious_rdv actual=done%0d data=%h expected=done0 data=%h",
               done_count - dc0, mem_bus.readdata, exp_hold);
    end
  endtask

  task automatic test_reset_mid();
    int dc0;
    preload(32'h6000, 32'h1111_2222);
    preload(32'h6004, 32'h3333_4444);
    preload(32'h6008, 32'h5566_7788);
    stall_per_beat = 0;
    rdv_delay = 0;
    mem_bus.read = 1'b1;
    mem_bus.write = 1'b0;
    mem_bus.datasize = 2'd3;
    mem_bus.address = 64'h6000;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (avm_bus.read !== 1'b1 || avm_bus.address !== 32'h6004) begin
      failures++;
      $display("FAIL rd1_reached actual=rd%0b a=%h expected=rd1 a=00006004", avm_bus.read, avm_bus.address);
    end
    dc0 = done_count;
    reset_n = 1'b0;
    mem_bus.read = 1'b0;
    #1;
    check_outputs_zero("reset_mid");
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (done_count != dc0 || mem_bus.done !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_done actual=%0d expected=0", done_count - dc0);
    end
    exp_hold = 64'd0;
    reset_n = 1'b1;
    @(negedge clk);
    check_txn("after_reset", 1'b1, 2, 64'h6009, 64'd0, 0, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      logic rd;
      int size;
      logic [63:0] addr, wd;
      rd = 1'($urandom_range(0, 1));
      size = $urandom_range(0, 3);
      addr = {$urandom, 32'h0} | 64'(32'h700 + $urandom_range(0, 47));
      wd = {$urandom, $urandom};
      check_txn($sformatf("rand%0d", k), rd, size, addr, wd,
                $urandom_range(0, 2), $urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_spurious_rdv();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mmix_mem_bridge.md
# mmix_mem_bridge

Memory-side bridge for the MMIX execution unit. It takes the load/store unit's level-held, right-justified, size-tagged 64-bit requests and turns them into aligned, big-endian accesses on a 32-bit Avalon-MM master port. It returns zero-extended, right-justified read data with a one-cycle `mem_done` pulse. It sits between the load/store unit's `mem_*` ports and the board memory interconnect.

## Interface
Parameters:
- ADDR_W, 32: bus byte-address width. Request address bits above ADDR_W-1 are discarded.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- mem_address  in  64  byte address from the load/store unit
- mem_datasize  in  2  0 byte, 1 wyde, 2 tetra, 3 octa
- mem_read  in  1  read request, level, held until mem_done
- mem_write  in  1  write request, level, held until mem_done
- mem_writedata  in  64  right-justified store data
- mem_readdata  out  64  right-justified, zero-extended load data
- mem_done  out  1  one-cycle completion pulse
- avm_address  out  ADDR_W  tetra-aligned byte address
- avm_byteenable  out  4  bit 3 = bits 31:24 = lowest byte address
- avm_read  out  1  read command
- avm_write  out  1  write command
- avm_writedata  out  32  write data
- avm_readdata  in  32  read data
- avm_waitrequest  in  1  slave stall
- avm_readdatavalid  in  1  read data valid

## Operation
- Effective address: EA = mem_address & ~((1<<mem_datasize)-1), truncated to ADDR_W. MMIX-style silent alignment; no fault is raised.
- Request capture: address, size, direction and write data are captured in IDLE only.
  - If mem_read and mem_write are both high, the read wins.
- Byte order is big-endian. Offset o = EA[1:0].
  - byte: byteenable = 4'b1000 >> o.
  - wyde: 4'b1100 (o=0) or 4'b0011 (o=2).
  - tetra: 4'b1111.
  - Write data is replicated across lanes (byte ×4, wyde ×2).
- Octa: two beats.
  - Beat 0 at EA carries bits 63:32.
  - Beat 1 at EA+4 carries bits 31:0.
  - Both beats use byteenable 4'b1111.
- Read return: the selected lane is right-justified into mem_readdata with upper bits zero. Sign extension is the load/store unit's job.
  - mem_readdata holds its value until the next read completes.
- States:
  - IDLE: request present → RD0 or WR0.
  - WR0: waitrequest low → WR1 if octa, else DONE.
  - WR1: waitrequest low → DONE.
  - RD0: command accepted, then readdatavalid → RD1 if octa, else DONE.
  - RD1: readdatavalid → DONE.
  - DONE: mem_done=1, all requests ignored → IDLE.
- Only one bus transaction is outstanding at a time. avm_read/avm_write drop in the cycle after acceptance (waitrequest low).
- Back-to-back requests (e.g. CSWAP read then write) are accepted in the IDLE cycle that follows DONE.

## Timing
- Reset (asynchronous): state IDLE, every output 0, mem_readdata 0.
  - Reset mid-transaction aborts immediately. The partial result is discarded and no mem_done is issued.
- Bus command outputs are registered and asserted the cycle after capture in IDLE.
- Zero-wait slave, readdatavalid one cycle after acceptance:
  - ≤tetra read: mem_done 3 cycles after the request is seen.
  - octa read: 5 cycles.
  - ≤tetra write: 2 cycles.
  - octa write: 3 cycles.
- Each cycle of waitrequest high, or of readdatavalid delay, adds exactly one cycle.
- Command signals and avm_address/byteenable/writedata are held stable while waitrequest is high.
- A readdatavalid arriving in any state other than RD0/RD1 is ignored.

## Structure
- Add mem_size_t (BYTE, WYDE, TETRA, OCTA) to the shared mmix_defs package. The load/store unit size decode will use it too.
- One combinational sub-module, mem_lane_steer: given size, offset and data, it produces byteenable, replicated write data and right-justified read extraction.
- FSM and registers live in mmix_mem_bridge.

## Test plan
- Byte write, mem_address=0x1003, writedata=0xAB → avm_address=0x1000, byteenable=4'b0001, writedata=0xABABABAB, mem_done at cycle +2.
- Wyde read at 0x2002 (misaligned 0x2003 also tried), slave returns 0x1122_3344 → mem_readdata=0x3344 for both, done at +3.
- Octa read at 0x3005, slave returns 0xDEADBEEF then 0x01234567 → beats at 0x3000/0x3004, mem_readdata=0xDEADBEEF01234567, done at +5.
- Octa write with waitrequest high 2 cycles on each beat → commands held stable, beat order high then low, done at +7.
- Read immediately followed by write (CSWAP pattern), plus simultaneous mem_read/mem_write → read first, write accepted in the IDLE cycle after DONE, exactly one mem_done per request.
- reset_n low during RD1 → outputs 0 the same cycle, no mem_done; a fresh tetra read after reset completes normally.
